// File: rtl/gshare_bpu_pkg.sv
// Shared types and helper functions for the gshare branch direction predictor.
package gshare_bpu_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    READY = 1'b1
  } bpu_state_e;

  // Table index hash. The result is 32 bits wide; the caller keeps the low
  // IDX_BITS. The history is zero-extended, so it only folds into the low
  // GHR_BITS of the PC-derived index.
  function automatic logic [31:0] bpu_hash(input logic [31:0] pc,
                                           input logic [31:0] ghr,
                                           input int          pc_lsb);
    return (pc >> pc_lsb) ^ ghr;
  endfunction

  // Saturating up/down counter step. The counter is ctr_bits wide and is
  // carried in a 32-bit container.
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          ctr_bits);
    logic [31:0] ctr_max;
    ctr_max = (32'd1 << ctr_bits) - 32'd1;
    if (taken) begin
      return (ctr == ctr_max) ? ctr : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

  // Weakly-not-taken value: the largest counter value whose MSB is still 0.
  function automatic logic [31:0] weak_nt(input int ctr_bits);
    return (32'd1 << (ctr_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_bpu_if.sv
// Fetch / decode / resolve side bundle of the gshare predictor.
interface gshare_bpu_if #(
  parameter int GHR_BITS = 8
);
  logic                ready;
  logic                query_valid;
  logic [31:0]         query_addr;
  logic                pred_valid;
  logic                pred_taken;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                hist_push;
  logic                hist_taken;
  logic                update_valid;
  logic [31:0]         update_addr;
  logic [GHR_BITS-1:0] update_ghr;
  logic                update_taken;
  logic                update_mispred;

  modport master (
    input  ready, pred_valid, pred_taken, pred_ghr,
    output query_valid, query_addr, hist_push, hist_taken,
           update_valid, update_addr, update_ghr, update_taken, update_mispred
  );

  modport slave (
    output ready, pred_valid, pred_taken, pred_ghr,
    input  query_valid, query_addr, hist_push, hist_taken,
           update_valid, update_addr, update_ghr, update_taken, update_mispred
  );
endinterface

// File: rtl/gshare_bpu_ghr.sv
// Speculative global history register with mispredict recovery.
module gshare_bpu_ghr #(
  parameter int GHR_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                push,
  input  logic                push_taken,
  input  logic                recover,
  input  logic [GHR_BITS-1:0] recover_ghr,
  input  logic                recover_taken,
  output logic [GHR_BITS-1:0] ghr
);

  logic [GHR_BITS-1:0] ghr_q;

  // Recovery wins over a same-cycle push: that push belongs to a younger,
  // wrong-path branch. Truncating the concatenation also covers GHR_BITS==1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (en && recover) begin
      ghr_q <= GHR_BITS'({recover_ghr, recover_taken});
    end else if (en && push) begin
      ghr_q <= GHR_BITS'({ghr_q, push_taken});
    end
  end

  assign ghr = ghr_q;

endmodule

// File: rtl/gshare_bpu.sv
// gshare direction predictor: self-initialising counter table indexed by
// PC xor speculative global history, 1-cycle query latency.
module gshare_bpu
  import gshare_bpu_pkg::*;
#(
  parameter int IDX_BITS = 10,
  parameter int CTR_BITS = 2,
  parameter int GHR_BITS = 8,
  parameter int PC_LSB   = 2
) (
  input  logic          clk,
  input  logic          rst,
  gshare_bpu_if.slave   bus
);

  localparam int ENTRIES = 2 ** IDX_BITS;
  typedef logic [IDX_BITS-1:0] idx_t;
  typedef logic [CTR_BITS-1:0] ctr_t;
  localparam ctr_t WEAK_NT  = CTR_BITS'(weak_nt(CTR_BITS));
  localparam idx_t LAST_IDX = idx_t'(ENTRIES - 1);

  bpu_state_e          state_q, state_d;
  idx_t                ptr_q;
  logic                init_we;
  logic                ready;
  logic [GHR_BITS-1:0] ghr;

  ctr_t                table_q [ENTRIES];

  idx_t                q_idx_p0;
  idx_t                u_idx_p0;
  logic                upd_we_p0;
  ctr_t                upd_ctr_p0;
  ctr_t                rd_ctr_p0;

  logic                vld_p1;
  logic                pred_taken_p1;
  logic [GHR_BITS-1:0] pred_ghr_p1;

  // Init FSM state and sweep pointer; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) begin
        ptr_q <= ptr_q + idx_t'(1);
      end
    end
  end

  // Next state: sweep every entry once, then serve forever.
  always_comb begin
    state_d = state_q;
    init_we = 1'b0;
    case (state_q)
      INIT: begin
        init_we = 1'b1;
        if (ptr_q == LAST_IDX) begin
          state_d = READY;
        end
      end
      READY: state_d = READY;
      default: state_d = INIT;
    endcase
  end

  assign ready = (state_q == READY);

  gshare_bpu_ghr #(
    .GHR_BITS(GHR_BITS)
  ) u_ghr (
    .clk          (clk),
    .rst          (rst),
    .en           (ready),
    .push         (bus.hist_push),
    .push_taken   (bus.hist_taken),
    .recover      (bus.update_valid && bus.update_mispred),
    .recover_ghr  (bus.update_ghr),
    .recover_taken(bus.update_taken),
    .ghr          (ghr)
  );

  // ---- stage p0: hash, counter read-modify-write, query read with bypass ----
  assign q_idx_p0   = IDX_BITS'(bpu_hash(bus.query_addr, 32'(ghr), PC_LSB));
  assign u_idx_p0   = IDX_BITS'(bpu_hash(bus.update_addr, 32'(bus.update_ghr), PC_LSB));
  assign upd_we_p0  = ready && bus.update_valid;
  assign upd_ctr_p0 = CTR_BITS'(sat_ctr_next(32'(table_q[u_idx_p0]), bus.update_taken, CTR_BITS));
  // A same-cycle update to the queried entry is forwarded so the prediction
  // reflects every write up to and including the query cycle.
  assign rd_ctr_p0  = (upd_we_p0 && (u_idx_p0 == q_idx_p0)) ? upd_ctr_p0 : table_q[q_idx_p0];

  // Single table write port: init sweep has priority, otherwise training.
  always_ff @(posedge clk) begin
    if (init_we) begin
      table_q[ptr_q] <= WEAK_NT;
    end else if (upd_we_p0) begin
      table_q[u_idx_p0] <= upd_ctr_p0;
    end
  end

  // ---- stage p1: registered prediction; direction/history hold when idle ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      pred_taken_p1 <= 1'b0;
      pred_ghr_p1   <= '0;
    end else if (ready && bus.query_valid) begin
      vld_p1        <= 1'b1;
      pred_taken_p1 <= rd_ctr_p0[CTR_BITS-1];
      pred_ghr_p1   <= ghr;
    end else begin
      vld_p1        <= 1'b0;
    end
  end

  assign bus.ready      = ready;
  assign bus.pred_valid = vld_p1;
  assign bus.pred_taken = pred_taken_p1;
  assign bus.pred_ghr   = pred_ghr_p1;

endmodule

// File: tb/tb_gshare_bpu.sv
// Directed bench for gshare_bpu with a 16-entry table and 4-bit history.
module tb_gshare_bpu;

  localparam int IDX_BITS = 4;
  localparam int CTR_BITS = 2;
  localparam int GHR_BITS = 4;
  localparam int PC_LSB   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n;

  gshare_bpu_if #(.GHR_BITS(GHR_BITS)) bus ();

  gshare_bpu #(
    .IDX_BITS(IDX_BITS),
    .CTR_BITS(CTR_BITS),
    .GHR_BITS(GHR_BITS),
    .PC_LSB  (PC_LSB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs;
    bus.query_valid    = 1'b0;
    bus.query_addr     = '0;
    bus.hist_push      = 1'b0;
    bus.hist_taken     = 1'b0;
    bus.update_valid   = 1'b0;
    bus.update_addr    = '0;
    bus.update_ghr     = '0;
    bus.update_taken   = 1'b0;
    bus.update_mispred = 1'b0;
  endtask

  // Counts edges until ready rises; 0 means it never did within the budget.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (bus.ready === 1'b1) begin
        cnt = i;
        break;
      end
    end
  endtask

  task automatic query(input logic [31:0] addr);
    bus.query_valid = 1'b1;
    bus.query_addr  = addr;
    tick();
    bus.query_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] addr, input logic [GHR_BITS-1:0] g, input logic t);
    bus.update_valid = 1'b1;
    bus.update_addr  = addr;
    bus.update_ghr   = g;
    bus.update_taken = t;
    tick();
    bus.update_valid = 1'b0;
  endtask

  task automatic push(input logic t);
    bus.hist_push  = 1'b1;
    bus.hist_taken = t;
    tick();
    bus.hist_push  = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_pred_valid", 32'(bus.pred_valid), 0);
    chk("rst_pred_taken", 32'(bus.pred_taken), 0);
    chk("rst_pred_ghr", 32'(bus.pred_ghr), 0);

    rst = 1'b0;
    wait_ready(n);
    chk("init_cycles", 32'(n), 16);

    // Fresh table: every entry weakly not taken.
    query(32'h40);
    chk("q40_valid", 32'(bus.pred_valid), 1);
    chk("q40_taken", 32'(bus.pred_taken), 0);
    chk("q40_ghr", 32'(bus.pred_ghr), 0);
    tick();
    chk("idle_valid", 32'(bus.pred_valid), 0);

    // Entry 0: 01 -> 10 -> 11 -> 11 (saturate).
    upd(32'h100, 4'h0, 1'b1);
    upd(32'h100, 4'h0, 1'b1);
    upd(32'h100, 4'h0, 1'b1);
    query(32'h100);
    chk("sat_hi_taken", 32'(bus.pred_taken), 1);
    upd(32'h100, 4'h0, 1'b0);
    query(32'h100);
    chk("dec_10_taken", 32'(bus.pred_taken), 1);
    upd(32'h100, 4'h0, 1'b0);
    query(32'h100);
    chk("dec_01_taken", 32'(bus.pred_taken), 0);

    // Entry 7 strongly taken, then GHR=0111 makes PC 0x100 hash to 7.
    upd(32'h100, 4'h7, 1'b1);
    upd(32'h100, 4'h7, 1'b1);
    push(1'b1);
    push(1'b1);
    push(1'b1);
    query(32'h100);
    chk("hist_ghr", 32'(bus.pred_ghr), 32'h7);
    chk("hist_taken_idx7", 32'(bus.pred_taken), 1);

    // Mispredict recovery beats a same-cycle push; the query sees old GHR.
    bus.hist_push      = 1'b1;
    bus.hist_taken     = 1'b1;
    bus.update_valid   = 1'b1;
    bus.update_mispred = 1'b1;
    bus.update_addr    = 32'h100;
    bus.update_ghr     = 4'h5;
    bus.update_taken   = 1'b0;
    bus.query_valid    = 1'b1;
    bus.query_addr     = 32'h0;
    tick();
    clear_inputs();
    chk("pre_change_ghr", 32'(bus.pred_ghr), 32'h7);
    chk("pre_change_taken", 32'(bus.pred_taken), 1);
    query(32'h0);
    chk("recover_ghr", 32'(bus.pred_ghr), 32'hA);
    chk("recover_taken", 32'(bus.pred_taken), 0);

    // Mispredict flag without update_valid is ignored.
    bus.update_mispred = 1'b1;
    bus.update_ghr     = 4'h0;
    bus.update_taken   = 1'b1;
    tick();
    clear_inputs();
    query(32'h0);
    chk("mispred_no_valid", 32'(bus.pred_ghr), 32'hA);

    // Shift out MSB: 1010 -> 0100. Same-cycle update+query on entry 4 bypasses.
    push(1'b0);
    bus.update_valid = 1'b1;
    bus.update_addr  = 32'h100;
    bus.update_ghr   = 4'h4;
    bus.update_taken = 1'b1;
    bus.query_valid  = 1'b1;
    bus.query_addr   = 32'h100;
    tick();
    clear_inputs();
    chk("bypass_ghr", 32'(bus.pred_ghr), 32'h4);
    chk("bypass_taken", 32'(bus.pred_taken), 1);
    tick();
    chk("hold_valid", 32'(bus.pred_valid), 0);
    chk("hold_taken", 32'(bus.pred_taken), 1);
    chk("hold_ghr", 32'(bus.pred_ghr), 32'h4);

    // Reset mid-INIT (ptr=7) restarts the full sweep; INIT ignores traffic.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_init_ready", 32'(bus.ready), 0);
    rst = 1'b1;
    tick();
    chk("rerst_ready", 32'(bus.ready), 0);
    chk("rerst_valid", 32'(bus.pred_valid), 0);
    chk("rerst_ghr", 32'(bus.pred_ghr), 0);
    rst = 1'b0;
    bus.update_valid = 1'b1;
    bus.update_addr  = 32'h100;
    bus.update_ghr   = 4'h0;
    bus.update_taken = 1'b1;
    bus.hist_push    = 1'b1;
    bus.hist_taken   = 1'b1;
    bus.query_valid  = 1'b1;
    bus.query_addr   = 32'h100;
    wait_ready(n);
    clear_inputs();
    chk("reinit_cycles", 32'(n), 16);
    query(32'h100);
    chk("reinit_ghr", 32'(bus.pred_ghr), 0);
    chk("reinit_e0_taken", 32'(bus.pred_taken), 0);
    query(32'h110);
    chk("reinit_e4_taken", 32'(bus.pred_taken), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
